// File: rtl/if_stage_pc_unit_if.sv
// ---------------------------------------------------------------------------
// if_stage_pc_unit_if
//
// Groups the signals between the instruction-fetch stage and its neighbours:
// the hazard unit, the ID stage and instruction memory.
//
// Modports:
//   master : the environment side. It drives the stall/flush controls, the
//            redirect targets, the exception/interrupt lines and the fetched
//            instruction word. It observes the fetch address and IF/ID.
//   slave  : the fetch stage itself (if_stage_pc_unit).
//
// Transfer semantics: there is no valid/ready handshake on this boundary.
// IF/ID advances on every rising clk edge unless pc_hold is high.
// if_id_valid qualifies if_id_instr: a 0 means the ID stage holds a bubble.
// instr_in must be the memory word at the current pc within the same cycle.
// ---------------------------------------------------------------------------
interface if_stage_pc_unit_if;
  // hazard unit
  logic        pc_hold;
  logic        if_id_clear;
  // next-pc selection from ID
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  // trap sources
  logic        exc;
  logic        irq;
  // instruction memory
  logic [31:0] instr_in;
  logic [31:0] pc;
  // IF/ID register
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  // trap state
  logic [31:0] epc;
  logic        trap_taken;

  modport master (
    output pc_hold, if_id_clear, pc_src, branch_target, jump_target,
           jr_target, exc, irq, instr_in,
    input  pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc, trap_taken
  );

  modport slave (
    input  pc_hold, if_id_clear, pc_src, branch_target, jump_target,
           jr_target, exc, irq, instr_in,
    output pc, if_id_instr, if_id_pc_plus4, if_id_valid, epc, trap_taken
  );
endinterface

// File: rtl/if_stage_pc_unit.sv
// ---------------------------------------------------------------------------
// if_stage_pc_unit
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns:
//   - the PC register and next-PC selection (sequential, branch, jump, jr)
//   - the IF/ID pipeline register (instruction, PC+4, valid)
//   - exception/interrupt redirection and the EPC register
//
// Kernel mode is pc[31] = 1. Interrupts are masked while in kernel mode.
// Branches and jumps keep the current mode. Only jr/jalr can change it.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : if_stage_pc_unit_if.slave, which carries
//           pc_hold, if_id_clear   - stall / flush from the hazard unit
//           pc_src, *_target       - next-pc select and redirect targets
//           exc, irq               - undefined-instr exception, external irq
//           instr_in, pc           - instruction memory read data / address
//           if_id_instr, if_id_pc_plus4, if_id_valid - IF/ID register
//           epc, trap_taken        - saved return address, 1-cycle trap pulse
// ---------------------------------------------------------------------------
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0004,
  parameter logic [31:0] IRQ_VEC  = 32'h8000_0008
) (
  input  logic               clk,
  input  logic               reset,
  if_stage_pc_unit_if.slave  bus
);

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic [31:0] epc_q;
  logic        trap_q;
  logic        irq_prev_q;
  logic        irq_pend_q;

  // -------------------------------------------------------------------------
  // Combinational next-state signals
  // -------------------------------------------------------------------------
  logic [31:0] seq_pc;
  logic [31:0] norm_pc;
  logic        irq_edge;
  logic        irq_acc;
  logic        exc_acc;
  logic        trap_acc;

  logic [31:0] pc_d;
  logic [31:0] epc_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        irq_pend_d;

  // The mode bit is carried through unchanged. Only the low 31 bits count,
  // so a sequential fetch past 7FFF_FFFC wraps to 0 inside the same mode.
  assign seq_pc = {pc_q[31], pc_q[30:0] + 31'd4};

  // Branch and jump targets inherit the current mode bit. jr is the only
  // path that can move between kernel and user space.
  always_comb begin
    norm_pc = seq_pc;
    case (bus.pc_src)
      SRC_SEQ:    norm_pc = seq_pc;
      SRC_BRANCH: norm_pc = {pc_q[31], bus.branch_target[30:0]};
      SRC_JUMP:   norm_pc = {pc_q[31], bus.jump_target[30:0]};
      default:    norm_pc = bus.jr_target;
    endcase
  end

  // irq is a level input. Only a rising edge arms a request, so a line
  // that stays high produces exactly one trap.
  assign irq_edge = bus.irq & ~irq_prev_q;

  // A pending interrupt waits while any of these is true: kernel mode, a
  // stalled pipeline, or a same-cycle exception. The exception wins, and
  // the interrupt stays pending for later.
  assign irq_acc  = irq_pend_q & ~pc_q[31] & ~bus.pc_hold & ~bus.exc;

  // An exception is only real if ID holds a real instruction. It is taken
  // even when the pipeline is held or the core is in kernel mode.
  assign exc_acc  = bus.exc & valid_q;

  assign trap_acc = exc_acc | irq_acc;

  // Pending flag: a new edge sets it, acceptance clears it. If both happen
  // in the same cycle the set wins, so the later request is not lost.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_edge) begin
      irq_pend_d = 1'b1;
    end else if (irq_acc) begin
      irq_pend_d = 1'b0;
    end
  end

  // Next PC and EPC.
  // On an exception, EPC gets the PC+4 of the faulting instruction in ID.
  // On an interrupt, EPC gets the address the program would have fetched
  // next. That includes a branch or jump being taken in the same cycle.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    if (exc_acc) begin
      pc_d  = EXC_VEC;
      epc_d = pc_plus4_q;
    end else if (irq_acc) begin
      pc_d  = IRQ_VEC;
      epc_d = norm_pc;
    end else if (bus.pc_hold) begin
      pc_d  = pc_q;
    end else begin
      pc_d  = norm_pc;
    end
  end

  // IF/ID next state. A trap squashes the word being fetched. A hold freezes
  // ID and takes priority over a flush: the hazard unit raises the flush
  // again once the stall is released.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (trap_acc) begin
      instr_d    = 32'h0000_0000;
      pc_plus4_d = seq_pc;
      valid_d    = 1'b0;
    end else if (bus.pc_hold) begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else if (bus.if_id_clear) begin
      instr_d    = 32'h0000_0000;
      pc_plus4_d = seq_pc;
      valid_d    = 1'b0;
    end else begin
      instr_d    = bus.instr_in;
      pc_plus4_d = seq_pc;
      valid_d    = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      epc_q      <= 32'h0000_0000;
      trap_q     <= 1'b0;
      irq_prev_q <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      epc_q      <= epc_d;
      trap_q     <= trap_acc;
      irq_prev_q <= bus.irq;
      irq_pend_q <= irq_pend_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc_plus4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.epc            = epc_q;
  assign bus.trap_taken     = trap_q;

endmodule

// File: tb/tb_if_stage_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_if_stage_pc_unit
//
// Directed bench for if_stage_pc_unit. Instruction memory is modelled as
// instr_in = pc, so the expected if_id_instr of each step is simply the pc
// of the step before. Each table row gives the inputs for one clock edge and
// the register values expected just after that edge.
// ---------------------------------------------------------------------------
module tb_if_stage_pc_unit;

  logic clk;
  logic reset;

  if_stage_pc_unit_if bus ();

  if_stage_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: word at address a is a
  assign bus.instr_in = bus.pc;

  typedef struct {
    logic        hold;
    logic        clr;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic        exc;
    logic        irq;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic [31:0] e_epc;
    logic        e_trap;
  } vec_t;

  localparam int NV = 28;
  vec_t vt[NV];

  int checks;
  int failures;

  function automatic vec_t mk(
    input logic hold, input logic clr, input logic [1:0] src,
    input logic [31:0] tgt, input logic exc, input logic irq,
    input logic [31:0] e_pc, input logic [31:0] e_instr,
    input logic [31:0] e_pp4, input logic e_valid,
    input logic [31:0] e_epc, input logic e_trap);
    vec_t v;
    v.hold = hold; v.clr = clr; v.src = src; v.tgt = tgt;
    v.exc = exc; v.irq = irq;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pp4 = e_pp4;
    v.e_valid = e_valid; v.e_epc = e_epc; v.e_trap = e_trap;
    return v;
  endfunction

  // driver: the unselected targets carry junk so a wrong mux leg shows up
  task automatic drive(input logic hold, input logic clr, input logic [1:0] src,
                       input logic [31:0] tgt, input logic exc, input logic irq);
    bus.pc_hold       = hold;
    bus.if_id_clear   = clr;
    bus.pc_src        = src;
    bus.branch_target = (src == 2'd1) ? tgt : 32'h1357_9BDC;
    bus.jump_target   = (src == 2'd2) ? tgt : 32'h2468_ACE0;
    bus.jr_target     = (src == 2'd3) ? tgt : 32'hDEAD_BEE0;
    bus.exc           = exc;
    bus.irq           = irq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_instr, input logic [31:0] e_pp4,
                         input logic e_valid, input logic [31:0] e_epc,
                         input logic e_trap);
    chk({tag, " pc"},        bus.pc,                    e_pc);
    chk({tag, " instr"},     bus.if_id_instr,           e_instr);
    chk({tag, " pc_plus4"},  bus.if_id_pc_plus4,        e_pp4);
    chk({tag, " valid"},     {31'd0, bus.if_id_valid},  {31'd0, e_valid});
    chk({tag, " epc"},       bus.epc,                   e_epc);
    chk({tag, " trap"},      {31'd0, bus.trap_taken},   {31'd0, e_trap});
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(vt[i].hold, vt[i].clr, vt[i].src, vt[i].tgt, vt[i].exc, vt[i].irq);
      step();
      chk_all($sformatf("row%0d", i), vt[i].e_pc, vt[i].e_instr, vt[i].e_pp4,
              vt[i].e_valid, vt[i].e_epc, vt[i].e_trap);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          hold clr src tgt           exc irq  pc            instr         pc_plus4      v  epc           trap
    // free-running kernel fetch out of reset
    vt[0]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 1, 32'h0,        0);
    vt[1]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 1, 32'h0,        0);
    vt[2]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h8000_000C, 32'h8000_0008, 32'h8000_000C, 1, 32'h0,        0);
    // jr into user space, hold 2 cycles (second with clear: hold wins)
    vt[3]  = mk(0, 0, 3, 32'h0000_0040,  0, 0, 32'h0000_0040, 32'h8000_000C, 32'h8000_0010, 1, 32'h0,        0);
    vt[4]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0000_0040, 32'h8000_000C, 32'h8000_0010, 1, 32'h0,        0);
    vt[5]  = mk(1, 1, 0, 32'h0,          0, 0, 32'h0000_0040, 32'h8000_000C, 32'h8000_0010, 1, 32'h0,        0);
    // branch with bit31 set in target stays in user mode; flush IF/ID
    vt[6]  = mk(0, 1, 1, 32'h8000_0100,  0, 0, 32'h0000_0100, 32'h0,         32'h0000_0044, 0, 32'h0,        0);
    vt[7]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0000_0104, 32'h0000_0100, 32'h0000_0104, 1, 32'h0,        0);
    // jump to 0200 (mode forced) while irq rises -> pending
    vt[8]  = mk(0, 1, 2, 32'h8000_0200,  0, 1, 32'h0000_0200, 32'h0,         32'h0000_0108, 0, 32'h0,        0);
    // interrupt accepted at pc=0200
    vt[9]  = mk(0, 0, 0, 32'h0,          0, 1, 32'h8000_0008, 32'h0,         32'h0000_0204, 0, 32'h0000_0204, 1);
    // (10 cycles of irq held high run by hand between the two row groups)
    vt[10] = mk(0, 0, 3, 32'h8000_0020,  0, 0, 32'h8000_0020, 32'h8000_0030, 32'h8000_0034, 1, 32'h0000_0204, 0);
    // irq edge in kernel mode: stays pending
    vt[11] = mk(0, 0, 0, 32'h0,          0, 1, 32'h8000_0024, 32'h8000_0020, 32'h8000_0024, 1, 32'h0000_0204, 0);
    vt[12] = mk(0, 0, 0, 32'h0,          0, 1, 32'h8000_0028, 32'h8000_0024, 32'h8000_0028, 1, 32'h0000_0204, 0);
    vt[13] = mk(0, 0, 3, 32'h0000_0300,  0, 1, 32'h0000_0300, 32'h8000_0028, 32'h8000_002C, 1, 32'h0000_0204, 0);
    vt[14] = mk(0, 0, 0, 32'h0,          0, 1, 32'h8000_0008, 32'h0,         32'h0000_0304, 0, 32'h0000_0304, 1);
    vt[15] = mk(0, 0, 0, 32'h0,          0, 0, 32'h8000_000C, 32'h8000_0008, 32'h8000_000C, 1, 32'h0000_0304, 0);
    // exception with hold and a same-cycle irq edge
    vt[16] = mk(0, 0, 3, 32'h0000_004C,  0, 0, 32'h0000_004C, 32'h8000_000C, 32'h8000_0010, 1, 32'h0000_0304, 0);
    vt[17] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0000_0050, 32'h0000_004C, 32'h0000_0050, 1, 32'h0000_0304, 0);
    vt[18] = mk(1, 0, 0, 32'h0,          1, 1, 32'h8000_0004, 32'h0,         32'h0000_0054, 0, 32'h0000_0050, 1);
    vt[19] = mk(0, 0, 0, 32'h0,          0, 1, 32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 1, 32'h0000_0050, 0);
    vt[20] = mk(0, 0, 3, 32'h0000_0050,  0, 1, 32'h0000_0050, 32'h8000_0008, 32'h8000_000C, 1, 32'h0000_0050, 0);
    vt[21] = mk(0, 0, 0, 32'h0,          0, 1, 32'h8000_0008, 32'h0,         32'h0000_0054, 0, 32'h0000_0054, 1);
    vt[22] = mk(0, 0, 0, 32'h0,          0, 0, 32'h8000_000C, 32'h8000_0008, 32'h8000_000C, 1, 32'h0000_0054, 0);
    // user-space wrap of the low 31 bits
    vt[23] = mk(0, 0, 3, 32'h7FFF_FFFC,  0, 0, 32'h7FFF_FFFC, 32'h8000_000C, 32'h8000_0010, 1, 32'h0000_0054, 0);
    vt[24] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0000_0000, 32'h7FFF_FFFC, 32'h0000_0000, 1, 32'h0000_0054, 0);
    // exc while ID holds a bubble is ignored
    vt[25] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0000_0004, 32'h0,         32'h0000_0004, 0, 32'h0000_0054, 0);
    vt[26] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008, 1, 32'h0000_0054, 0);
    // arm an irq just before reaching 0400 (accepted next edge unless reset)
    vt[27] = mk(0, 0, 3, 32'h0000_0400,  0, 1, 32'h0000_0400, 32'h0000_0008, 32'h0000_000C, 1, 32'h0000_0054, 0);

    // reset state
    drive(0, 0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    #2;
    chk_all("reset", 32'h8000_0000, 32'h0, 32'h0, 0, 32'h0, 0);
    step();
    reset = 1'b0;

    run_rows(0, 9);

    // irq stays high 10 more cycles: no new edge, no second trap
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 32'h0, 0, 1);
      step();
      chk($sformatf("irqhigh%0d pc", k), bus.pc, 32'h8000_000C + 32'(4 * k));
      chk($sformatf("irqhigh%0d trap", k), {31'd0, bus.trap_taken}, 32'd0);
      chk($sformatf("irqhigh%0d epc", k), bus.epc, 32'h0000_0204);
    end

    run_rows(10, 27);

    // async reset with an interrupt pending at pc=0400
    reset = 1'b1;
    #1;
    chk_all("midreset", 32'h8000_0000, 32'h0, 32'h0, 0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    step();
    chk("midreset held pc", bus.pc, 32'h8000_0000);
    reset = 1'b0;
    step();
    chk_all("post0", 32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 1, 32'h0, 0);
    // go to user mode: a surviving pending irq would trap on the next edge
    drive(0, 0, 3, 32'h0000_0600, 0, 0);
    step();
    chk_all("post1", 32'h0000_0600, 32'h8000_0004, 32'h8000_0008, 1, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 0, 0);
    step();
    chk_all("post2", 32'h0000_0604, 32'h0000_0600, 32'h0000_0604, 1, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
